// File: rtl/dff_pkg.sv
// Shared types and sizing helpers for the dff_shift_bank register bank.
// Mode encodings are a typed enum so every consumer decodes the same values.
package dff_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_LOAD   = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_t;

    // Width needed to count 0..depth inclusive.
    function automatic int fill_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One WIDTH-bit register stage with clock enable and synchronous active-low clear.
module dff_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/dff_shift_bank.sv
// DEPTH-stage word shift register with hold/shift/load/rotate modes, a tap mux,
// occupancy counting and a one-cycle overflow pulse on shifting past full.
module dff_shift_bank
    import dff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int TAP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int FILL_W = fill_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       d,
    input  logic [DEPTH*WIDTH-1:0] load_data,
    input  logic [TAP_W-1:0]       tap_sel,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       tap_q,
    output logic [DEPTH*WIDTH-1:0] q_all,
    output logic [FILL_W-1:0]      fill,
    output logic                   full,
    output logic                   empty,
    output logic                   ovf
);

    localparam logic [FILL_W-1:0] FULL_COUNT = DEPTH[FILL_W-1:0];

    mode_t            w_mode;
    logic             w_stage_en;
    logic [WIDTH-1:0] w_stage    [DEPTH];
    logic [WIDTH-1:0] w_next     [DEPTH];
    logic [WIDTH-1:0] w_shift_in [DEPTH];
    logic [WIDTH-1:0] w_rot_in   [DEPTH];

    logic [FILL_W-1:0] r_fill;
    logic              r_ovf;

    assign w_mode     = mode_t'(mode);
    assign w_stage_en = en && (w_mode != MODE_HOLD);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            // Stage 0 is fed from d on shift and from the last stage on rotate.
            if (gi == 0) begin : g_head
                assign w_shift_in[gi] = d;
                assign w_rot_in[gi]   = w_stage[DEPTH-1];
            end else begin : g_body
                assign w_shift_in[gi] = w_stage[gi-1];
                assign w_rot_in[gi]   = w_stage[gi-1];
            end

            assign w_next[gi] = (w_mode == MODE_LOAD)   ? load_data[gi*WIDTH +: WIDTH] :
                                (w_mode == MODE_ROTATE) ? w_rot_in[gi]   :
                                (w_mode == MODE_SHIFT)  ? w_shift_in[gi] :
                                                          w_stage[gi];

            dff_stage #(
                .WIDTH(WIDTH)
            ) u_stage (
                .clk (clk),
                .clr (clr),
                .en  (w_stage_en),
                .d   (w_next[gi]),
                .q   (w_stage[gi])
            );

            assign q_all[gi*WIDTH +: WIDTH] = w_stage[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_fill <= '0;
            r_ovf  <= 1'b0;
        end else if (!en) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            case (w_mode)
                MODE_SHIFT: begin
                    if (r_fill == FULL_COUNT) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_fill <= r_fill + FILL_W'(1);
                    end
                end
                MODE_LOAD: r_fill <= FULL_COUNT;
                default:   r_fill <= r_fill;
            endcase
        end
    end

    // Out-of-range selects match no stage and therefore read as zero.
    always_comb begin
        tap_q = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == i[TAP_W-1:0]) begin
                tap_q = w_stage[i];
            end
        end
    end

    assign q     = w_stage[DEPTH-1];
    assign fill  = r_fill;
    assign full  = (r_fill == FULL_COUNT);
    assign empty = (r_fill == '0);
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_dff_shift_bank.sv
// Self-checking bench for dff_shift_bank: directed scenarios plus random traffic
// compared against a queue-based model of the word pipeline.
module tb_dff_shift_bank;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int TAP_W  = 2;
    localparam int FILL_W = 3;

    logic                   clk = 1'b0;
    logic                   clr;
    logic                   en;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       d;
    logic [DEPTH*WIDTH-1:0] load_data;
    logic [TAP_W-1:0]       tap_sel;
    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       tap_q;
    logic [DEPTH*WIDTH-1:0] q_all;
    logic [FILL_W-1:0]      fill;
    logic                   full;
    logic                   empty;
    logic                   ovf;

    int total = 0;
    int bad   = 0;

    // Model: m_words[i] is the word in stage i.
    logic [WIDTH-1:0] m_words[$];
    int               m_fill;
    logic             m_ovf;

    dff_shift_bank #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .load_data (load_data),
        .tap_sel   (tap_sel),
        .q         (q),
        .tap_q     (tap_q),
        .q_all     (q_all),
        .fill      (fill),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DEPTH*WIDTH-1:0] model_all();
        logic [DEPTH*WIDTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i*WIDTH +: WIDTH] = m_words[i];
        return v;
    endfunction

    task automatic model_clear();
        m_words.delete();
        for (int i = 0; i < DEPTH; i++) m_words.push_back('0);
        m_fill = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] w;
        if (!clr) begin
            model_clear();
        end else if (!en) begin
            m_ovf = 1'b0;
        end else begin
            m_ovf = 1'b0;
            case (mode)
                2'b01: begin
                    m_ovf = (m_fill == DEPTH);
                    if (m_fill < DEPTH) m_fill++;
                    m_words.push_front(d);
                    w = m_words.pop_back();
                end
                2'b10: begin
                    for (int i = 0; i < DEPTH; i++) m_words[i] = load_data[i*WIDTH +: WIDTH];
                    m_fill = DEPTH;
                end
                2'b11: begin
                    w = m_words.pop_back();
                    m_words.push_front(w);
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string ctx);
        logic [WIDTH-1:0] exp_tap;
        exp_tap = (int'(tap_sel) < DEPTH) ? m_words[tap_sel] : '0;
        chk({ctx, ".q_all"}, 64'(q_all), 64'(model_all()));
        chk({ctx, ".q"},     64'(q),     64'(m_words[DEPTH-1]));
        chk({ctx, ".tap_q"}, 64'(tap_q), 64'(exp_tap));
        chk({ctx, ".fill"},  64'(fill),  64'(m_fill));
        chk({ctx, ".full"},  64'(full),  64'(m_fill == DEPTH));
        chk({ctx, ".empty"}, 64'(empty), 64'(m_fill == 0));
        chk({ctx, ".ovf"},   64'(ovf),   64'(m_ovf));
    endtask

    task automatic step(input string ctx);
        model_edge();
        @(posedge clk);
        #1;
        check_all(ctx);
        $display("step %-10s clr=%b en=%b mode=%0d d=%02h q_all=%08h fill=%0d ovf=%b",
                 ctx, clr, en, mode, d, q_all, fill, ovf);
    endtask

    task automatic drive(input logic c, input logic e, input logic [1:0] m, input logic [WIDTH-1:0] dv);
        clr  = c;
        en   = e;
        mode = m;
        d    = dv;
    endtask

    initial begin
        logic [DEPTH*WIDTH-1:0] saved;
        logic [WIDTH-1:0]       fill_words [4];
        fill_words[0] = 8'h11; fill_words[1] = 8'h22;
        fill_words[2] = 8'h33; fill_words[3] = 8'h44;

        model_clear();
        load_data = '0;
        tap_sel   = '0;
        drive(1'b0, 1'b1, 2'b01, 8'h5A);
        step("reset0");
        step("reset1");
        chk("reset.empty", 64'(empty), 64'd1);

        // Random traffic, then clear with en low as well.
        for (int i = 0; i < 10; i++) begin
            load_data = {$urandom, $urandom};
            drive(1'b1, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom));
            step("prerand");
        end
        drive(1'b0, 1'b0, 2'b01, 8'hFF);
        step("clr_en0");
        chk("clr_en0.q_all", 64'(q_all), 64'd0);
        step("clr_en0b");

        // Fill and latency.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 2'b01, fill_words[i]);
            step("fill");
            chk("fill.count", 64'(fill), 64'(i + 1));
        end
        chk("fill.full",  64'(full),  64'd1);
        chk("fill.q",     64'(q),     64'h11);
        chk("fill.q_all", 64'(q_all), 64'h11223344);

        // Tap sweep (combinational, no edge).
        drive(1'b1, 1'b1, 2'b00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i);
            #1;
            chk("tap", 64'(tap_q), 64'(fill_words[3 - i]));
            $display("tap sel=%0d tap_q=%02h", i, tap_q);
        end
        tap_sel = '0;

        // Overflow pulse.
        drive(1'b1, 1'b1, 2'b01, 8'h55);
        step("ovf");
        chk("ovf.q",    64'(q),    64'h22);
        chk("ovf.fill", 64'(fill), 64'd4);
        chk("ovf.flag", 64'(ovf),  64'd1);
        drive(1'b1, 1'b1, 2'b00, 8'h00);
        step("ovf_hold");
        chk("ovf.drop", 64'(ovf), 64'd0);

        // Load and rotate.
        load_data = 32'hA1B2C3D4;
        drive(1'b1, 1'b1, 2'b10, 8'h00);
        step("load");
        chk("load.q", 64'(q), 64'hA1);
        drive(1'b1, 1'b1, 2'b11, 8'h00);
        step("rot1");
        chk("rot1.q",  64'(q),          64'hB2);
        chk("rot1.s0", 64'(q_all[7:0]), 64'hA1);
        for (int i = 0; i < 3; i++) step("rot");
        chk("rot4.q_all", 64'(q_all), 64'hA1B2C3D4);

        // Enable gating.
        saved = q_all;
        drive(1'b1, 1'b0, 2'b01, 8'hFF);
        for (int i = 0; i < 3; i++) step("en_off");
        chk("en_off.q_all", 64'(q_all), 64'(saved));
        chk("en_off.fill",  64'(fill),  64'd4);

        // Clear during a shift burst.
        drive(1'b0, 1'b1, 2'b00, 8'h00);
        step("pre_burst");
        drive(1'b1, 1'b1, 2'b01, 8'h01);
        step("burst");
        d = 8'h02;
        step("burst");
        drive(1'b0, 1'b1, 2'b01, 8'h03);
        step("burst_clr");
        chk("burst_clr.q_all", 64'(q_all), 64'd0);
        drive(1'b1, 1'b1, 2'b01, 8'h04);
        step("burst_after");
        chk("burst_after.fill", 64'(fill), 64'd1);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            load_data = {$urandom, $urandom};
            tap_sel   = 2'($urandom_range(0, 3));
            drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 7) != 0),
                  2'($urandom_range(0, 3)), 8'($urandom));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
